// File: rtl/if_prefetch.sv
// Instruction-fetch prefetch buffer: issues word fetches under a two-credit limit and
// queues returned instructions in a two-entry FIFO that feeds the IF/ID register.
module if_prefetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Branch,
  input  logic        Jump,
  input  logic [31:0] JumpAddr,
  input  logic        IFWrite,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction_if,
  output logic [31:0] PC,
  output logic        IF_valid,
  output logic        IF_flush
);
  localparam int unsigned XLEN   = 32;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned CRED_W = CNT_W + 1;

  logic [XLEN-1:0]  fifo_pc    [DEPTH];
  logic [XLEN-1:0]  fifo_instr [DEPTH];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] drop;
  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  resp_pc;

  logic             redirect;
  logic             accept;
  logic             resp;
  logic             push;
  logic             pop;
  logic [XLEN-1:0]  target;
  logic [CNT_W-1:0] inflight_next;

  // Credit check, handshake decode and head-of-queue presentation.
  always_comb begin
    redirect       = Branch | Jump;
    target         = JumpAddr & ~XLEN'(3);
    imem_req       = ~redirect & ~reset &
                     ((CRED_W'(count) + CRED_W'(outstanding)) < CRED_W'(DEPTH));
    imem_addr      = fetch_pc;
    accept         = imem_req & imem_ack;
    resp           = imem_rvalid & (outstanding != '0);
    push           = resp & (drop == '0) & ~redirect;
    IF_valid       = (count != '0);
    IF_flush       = redirect;
    pop            = IF_valid & IFWrite & ~redirect;
    Instruction_if = IF_valid ? fifo_instr[rd_ptr] : NOP_INSTR;
    PC             = IF_valid ? fifo_pc[rd_ptr] : resp_pc;
    inflight_next  = outstanding - CNT_W'(resp);
  end

  // FIFO payload storage; contents are only meaningful while counted.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= resp_pc;
      fifo_instr[wr_ptr] <= imem_rdata;
    end
  end

  // On redirect every request still in flight (dropped ones included) becomes stale.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
    end else if (redirect) begin
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= '0;
      fetch_pc    <= target;
      resp_pc     <= target;
      outstanding <= inflight_next;
      drop        <= inflight_next;
    end else begin
      if (accept) fetch_pc <= fetch_pc + XLEN'(4);
      if (push) begin
        wr_ptr  <= ~wr_ptr;
        resp_pc <= resp_pc + XLEN'(4);
      end
      if (pop) rd_ptr <= ~rd_ptr;
      if (resp && (drop != '0)) drop <= drop - CNT_W'(1);
      outstanding <= inflight_next + CNT_W'(accept);
      count       <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end
endmodule

// File: tb/tb_if_prefetch.sv
// Directed and randomized bench for if_prefetch against a queue-based model of the
// fetch stream: in-flight requests carry a stale mark, delivered entries form a queue.
module tb_if_prefetch;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        Branch;
  logic        Jump;
  logic [31:0] JumpAddr;
  logic        IFWrite;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] Instruction_if;
  logic [31:0] PC;
  logic        IF_valid;
  logic        IF_flush;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_prefetch #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .reset(reset), .Branch(Branch), .Jump(Jump), .JumpAddr(JumpAddr),
    .IFWrite(IFWrite), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .Instruction_if(Instruction_if),
    .PC(PC), .IF_valid(IF_valid), .IF_flush(IF_flush)
  );

  typedef struct { logic [31:0] pc; logic [31:0] instr; } entry_t;
  typedef struct { logic [31:0] addr; logic stale; } req_t;

  entry_t      fifo_q[$];
  req_t        infl_q[$];
  logic [31:0] m_fetch;
  logic [31:0] mem_addr_q[$];
  int          mem_rdy_q[$];
  logic [31:0] delivered[$];
  int          cyc = 0;
  int          ack_mode = 1;
  int          lat_lo = 1;
  int          lat_hi = 1;
  logic [31:0] salt = 32'h0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ salt;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fifo_q.delete();
    infl_q.delete();
    mem_addr_q.delete();
    mem_rdy_q.delete();
    m_fetch = RESET_PC;
  endtask

  // One clock: drive memory, check outputs against the model, advance the model.
  task automatic cycle();
    logic rv;
    logic exp_req;
    logic exp_flush;
    logic pop_now;
    req_t r;
    rv = (mem_rdy_q.size() > 0) && (mem_rdy_q[0] <= cyc);
    imem_rvalid = rv;
    if (rv) imem_rdata = mem_data(mem_addr_q[0]);
    else    imem_rdata = 32'hDEAD_BEEF;
    case (ack_mode)
      1:       imem_ack = 1'b1;
      2:       imem_ack = 1'b0;
      default: imem_ack = ($urandom_range(0, 3) != 0);
    endcase
    #1;
    exp_flush = Branch | Jump;
    exp_req   = !exp_flush && ((fifo_q.size() + infl_q.size()) < 2);
    chk1("if_flush", IF_flush, exp_flush);
    chk1("imem_req", imem_req, exp_req);
    chk("imem_addr", imem_addr, m_fetch);
    chk1("if_valid", IF_valid, fifo_q.size() != 0);
    if (fifo_q.size() != 0) begin
      chk("head_pc", PC, fifo_q[0].pc);
      chk("head_instr", Instruction_if, fifo_q[0].instr);
    end else begin
      chk("empty_instr", Instruction_if, NOP_INSTR);
    end
    if (IF_valid && IFWrite && !IF_flush) delivered.push_back(PC);
    // memory side follows what the DUT actually did
    if (rv) begin
      mem_addr_q.delete(0);
      mem_rdy_q.delete(0);
    end
    if (imem_req && imem_ack) begin
      mem_addr_q.push_back(imem_addr);
      mem_rdy_q.push_back(cyc + int'($urandom_range(lat_lo, lat_hi)));
    end
    // model side follows the rules
    pop_now = (fifo_q.size() != 0) && IFWrite && !exp_flush;
    if (exp_flush) begin
      if (rv && infl_q.size() != 0) infl_q.delete(0);
      foreach (infl_q[i]) infl_q[i].stale = 1'b1;
      fifo_q.delete();
      m_fetch = {JumpAddr[31:2], 2'b00};
    end else begin
      if (rv && infl_q.size() != 0) begin
        r = infl_q[0];
        infl_q.delete(0);
        if (!r.stale) fifo_q.push_back('{pc: r.addr, instr: mem_data(r.addr)});
      end
      if (pop_now) fifo_q.delete(0);
      if (exp_req && imem_ack) begin
        infl_q.push_back('{addr: m_fetch, stale: 1'b0});
        m_fetch = m_fetch + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // Reset from a negedge: outputs must clear at once, then request RESET_PC on release.
  task automatic do_reset();
    Branch = 1'b0;
    Jump = 1'b0;
    reset = 1'b1;
    imem_rvalid = 1'b0;
    imem_ack = 1'b0;
    #1;
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_valid", IF_valid, 1'b0);
    chk("rst_instr", Instruction_if, NOP_INSTR);
    chk("rst_pc", PC, RESET_PC);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk1("rel_req", imem_req, 1'b1);
    chk("rel_addr", imem_addr, RESET_PC);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] spc;
    logic found;
    reset = 1'b1; Branch = 1'b0; Jump = 1'b0; JumpAddr = 32'h0; IFWrite = 1'b1;
    imem_ack = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    model_reset();
    @(negedge clk);

    // streaming after reset, data = address, 1-cycle memory
    do_reset();
    delivered.delete();
    cycle();
    cycle();
    chk1("c2_valid", IF_valid, 1'b1);
    chk("c2_pc", PC, 32'h0);
    repeat (6) cycle();
    chk1("deliv_count", delivered.size() >= 3, 1'b1);
    for (int i = 0; i < 3; i++)
      chk("deliv_order", (delivered.size() > i) ? delivered[i] : 32'hFFFF_FFFF, 32'(4 * i));

    // stall: queue fills, fetch stops, head holds
    IFWrite = 1'b0;
    repeat (2) cycle();
    spc = (fifo_q.size() != 0) ? fifo_q[0].pc : 32'hFFFF_FFFF;
    repeat (3) cycle();
    chk("stall_pc", PC, spc);
    chk1("stall_req", imem_req, 1'b0);
    chk1("stall_valid", IF_valid, 1'b1);
    IFWrite = 1'b1;
    repeat (6) cycle();

    // reset with a full queue
    IFWrite = 1'b0;
    repeat (4) cycle();
    IFWrite = 1'b1;
    do_reset();

    // jump with two requests in flight
    salt = 32'hC0DE_0000;
    lat_lo = 3; lat_hi = 3; ack_mode = 1;
    cycle();
    cycle();
    Jump = 1'b1; JumpAddr = 32'h0000_0100;
    #1;
    chk1("jump_flush", IF_flush, 1'b1);
    chk1("jump_req", imem_req, 1'b0);
    cycle();
    Jump = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (IF_valid) found = 1'b1;
      else cycle();
    end
    chk1("jump_found", found, 1'b1);
    chk("jump_first_pc", PC, 32'h0000_0100);
    repeat (4) cycle();

    // branch coinciding with the only response
    do_reset();
    lat_lo = 1; lat_hi = 1; ack_mode = 1;
    cycle();
    ack_mode = 2;
    Branch = 1'b1; JumpAddr = 32'h0000_0200;
    cycle();
    Branch = 1'b0; ack_mode = 1;
    #1;
    chk1("br_req", imem_req, 1'b1);
    chk("br_addr", imem_addr, 32'h0000_0200);
    repeat (6) cycle();

    // fetch address wraps at the top of memory
    do_reset();
    Jump = 1'b1; JumpAddr = 32'hFFFF_FFFC;
    cycle();
    Jump = 1'b0;
    cycle();
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    repeat (6) cycle();

    // randomized traffic
    salt = $urandom();
    ack_mode = 0; lat_lo = 1; lat_hi = 3;
    for (int n = 0; n < 600; n++) begin
      if (n % 200 == 199) do_reset();
      IFWrite = ($urandom_range(0, 3) != 0);
      Branch = 1'b0;
      Jump = 1'b0;
      if ($urandom_range(0, 15) == 0) begin
        if ($urandom_range(0, 1) == 1) Branch = 1'b1;
        else Jump = 1'b1;
        JumpAddr = $urandom();
      end
      cycle();
    end
    Branch = 1'b0;
    Jump = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
